bank_conflict_scheduler: RTL
============================

Name: bank_conflict_scheduler

Overview:
- Sequences one batch of 8 lane accesses onto the 8 polynomial-coefficient memory banks of the poly-mul datapath.
- Splits a conflicting batch into conflict-free issue beats.
- Each beat drives the bank-input crossbar selects, the bank enables and the per-lane grant mask.
- Sits between the NTT address generator and the bank crossbar.

Parameters:
- BANK_W, 3, bank index width.
- LANES, 8, lanes per batch and number of banks; must equal 2**BANK_W.
- RCNT_W, 4, width of the beat counter; must hold LANES.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  batch offered.
- in_ready  output  1  scheduler can accept a batch.
- lane_mask  input  LANES  bit i=1: lane i participates in this batch.
- lane_bank  input  LANES*BANK_W  bank index of lane i in bits [i*BANK_W +: BANK_W].
- out_valid  output  1  issue beat present.
- out_ready  input  1  downstream consumes the beat.
- lane_grant  output  LANES  lanes served this beat.
- bank_en  output  LANES  bank b accessed this beat.
- bank_sel  output  LANES*BANK_W  lane index routed to bank b.
- done  output  1  one-cycle pulse, batch complete.
- rounds  output  RCNT_W  number of beats used by the batch; valid only while done=1.

Behaviour:
- Reset: asynchronous, active-low. Clock is clk, reset is rst_n. Reset returns the block to IDLE and clears pending, beat count and the empty flag. Output values in reset: in_ready=1, out_valid=0, lane_grant=0, bank_en=0, bank_sel=0, done=0, rounds=0.
- States:
  - IDLE: in_ready=1.
  - ISSUE: in_ready=0.
- Accept: in IDLE with in_valid=1:
  - latch lane_bank;
  - pending <= lane_mask;
  - beat count <= 0.
  - If lane_mask != 0: go to ISSUE. The first beat is visible the next cycle (latency 1).
  - If lane_mask == 0: stay in IDLE, and done=1 with rounds=0 the next cycle. out_valid never asserts for that batch.
- Beat computation is combinational from registered state only; there is no input-to-output path.
  - For each bank b: choose the lowest-index pending lane whose latched bank equals b.
  - bank_sel[b] = that lane index, bank_en[b]=1.
  - If no pending lane targets bank b: bank_sel[b]=0, bank_en[b]=0.
  - lane_grant = OR of the chosen lanes.
- out_valid = (state==ISSUE).
- Beat retirement: the beat retires when out_valid && out_ready.
  - pending <= pending & ~lane_grant;
  - beat count +1.
- Backpressure: while out_ready=0, pending and the beat count hold and all outputs stay stable.
- Completion:
  - done=1 on the retiring beat where pending & ~lane_grant == 0. It is combinational with that beat.
  - rounds = beat count + 1 on that beat.
  - The next cycle the block returns to IDLE.
- A new batch cannot be accepted in the same cycle as done from ISSUE. in_ready rises the cycle after done.
- Beat count bounds: minimum 1 beat when lanes are nonzero and all on distinct banks. Maximum LANES beats when all lanes target the same bank.
- Guarantees:
  - every masked lane is granted exactly once per batch;
  - no bank is granted to two lanes in one beat;
  - lanes outside lane_mask are never granted.
- in_valid while in ISSUE is ignored, not latched.
- Reset asserted mid-batch aborts the batch. No done pulse is produced.

Decomposition:
- Package poly_mul_pkg holds:
  - BANK_W and LANES defaults;
  - the state encoding (IDLE=0, ISSUE=1).
- Sub-module bank_lane_select, instantiated LANES times:
  - combinational priority encoder;
  - inputs: target bank, latched bank indices, pending mask;
  - outputs: sel and en.
- The top level holds the FSM, the pending register and the beat counter.

Test Plan:
- Permutation: mask=8'hFF, banks lane0..7 = 7,6,5,4,3,2,1,0 -> one beat, lane_grant=FF, bank_sel[7]=0, bank_sel[0]=7, bank_en=FF, done with rounds=1.
- All-same-bank: mask=FF, all banks=3 -> 8 beats, grants 01,02,04,…,80 in order; bank_en=08 on each beat; done with rounds=8.
- Partial conflict with backpressure:
  - setup: mask=FF, banks = 0,0,1,1,2,3,4,5;
  - out_ready=0 for 3 cycles -> first beat holds lane_grant=F5 stable;
  - then beat 2 shows lane_grant=0A;
  - done with rounds=2.
- Masked lanes: mask=8'h0F, banks all 2 -> grants 01,02,04,08; lanes 4-7 never granted; rounds=4.
- Empty batch: mask=00 -> no out_valid; done=1 with rounds=0 one cycle after accept; in_ready stays 1.
- Reset mid-batch: rst_n low during beat 3 of the all-same-bank case -> outputs return to reset values immediately, no done pulse; the next batch runs normally.

Source files
------------

// File: rtl/poly_mul_pkg.sv
// poly_mul_pkg: shared widths and FSM encoding for the poly-mul bank scheduler
package poly_mul_pkg;
  localparam int DEF_BANK_W = 3;
  localparam int DEF_LANES  = 8;
  localparam int DEF_RCNT_W = 4;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
endpackage

// File: rtl/bank_lane_select.sv
// bank_lane_select: picks the lowest-index pending lane that targets one bank
module bank_lane_select
  import poly_mul_pkg::*;
#(
  parameter int BANK_W = DEF_BANK_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic [BANK_W-1:0]       bank_i,
  input  logic [LANES*BANK_W-1:0] banks_i,
  input  logic [LANES-1:0]        pend_i,
  output logic [BANK_W-1:0]       sel_o,
  output logic                    en_o
);
  // scan high to low so the lowest matching lane wins
  always_comb begin
    sel_o = '0;
    en_o  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_i[i] && banks_i[i*BANK_W +: BANK_W] == bank_i) begin
        sel_o = BANK_W'(i);
        en_o  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bank_conflict_scheduler.sv
// bank_conflict_scheduler: splits a lane batch into conflict-free bank issue beats
module bank_conflict_scheduler
  import poly_mul_pkg::*;
#(
  parameter int BANK_W = DEF_BANK_W,
  parameter int LANES  = DEF_LANES,
  parameter int RCNT_W = DEF_RCNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        lane_mask,
  input  logic [LANES*BANK_W-1:0] lane_bank,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        lane_grant,
  output logic [LANES-1:0]        bank_en,
  output logic [LANES*BANK_W-1:0] bank_sel,
  output logic                    done,
  output logic [RCNT_W-1:0]       rounds
);
  state_e                  state_q, state_d;
  logic [LANES-1:0]        pending_q, pending_d;
  logic [LANES*BANK_W-1:0] banks_q, banks_d;
  logic [RCNT_W-1:0]       cnt_q, cnt_d;
  logic                    empty_q, empty_d;
  logic [LANES-1:0]        pend, rest;
  logic                    accept, fire;

  assign pend      = (state_q == ISSUE) ? pending_q : '0;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == ISSUE);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign rest      = pending_q & ~lane_grant;
  assign done      = empty_q || (fire && rest == '0);
  assign rounds    = empty_q ? '0 : done ? cnt_q + RCNT_W'(1) : '0;

  genvar b;
  for (b = 0; b < LANES; b++) begin : g_bank
    bank_lane_select #(.BANK_W(BANK_W), .LANES(LANES)) u_sel (
      .bank_i (BANK_W'(b)),
      .banks_i(banks_q),
      .pend_i (pend),
      .sel_o  (bank_sel[b*BANK_W +: BANK_W]),
      .en_o   (bank_en[b])
    );
  end

  // each enabled bank grants the lane routed to it
  always_comb begin
    lane_grant = '0;
    for (int k = 0; k < LANES; k++)
      if (bank_en[k]) lane_grant[bank_sel[k*BANK_W +: BANK_W]] = 1'b1;
  end

  // next-state: accept a batch in IDLE, retire beats in ISSUE
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    banks_d   = banks_q;
    cnt_d     = cnt_q;
    empty_d   = 1'b0;
    if (accept) begin
      banks_d   = lane_bank;
      pending_d = lane_mask;
      cnt_d     = '0;
      empty_d   = (lane_mask == '0);
      state_d   = (lane_mask != '0) ? ISSUE : IDLE;
    end else if (fire) begin
      pending_d = rest;
      cnt_d     = cnt_q + RCNT_W'(1);
      state_d   = (rest == '0) ? IDLE : ISSUE;
    end
  end

  // state registers, reset aborts any batch in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      banks_q   <= '0;
      cnt_q     <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      banks_q   <= banks_d;
      cnt_q     <= cnt_d;
      empty_q   <= empty_d;
    end
  end
endmodule
